// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring monitor.
// Helpers take a zero-extended vector so they work for any ring width up to VEC_W.
package ring_pkg;

  localparam int unsigned RING_N  = 5;
  localparam int unsigned PHASE_W = $clog2(RING_N);
  localparam int unsigned VEC_W   = 32;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // Rotate right by one within an n-bit ring: the expected next sample.
  function automatic logic [VEC_W-1:0] rot_next(input logic [VEC_W-1:0] v,
                                                input int unsigned n);
    return (v >> 1) | (VEC_W'(v[0]) << (n - 1));
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and phase encoder; ring[N-1] is phase 0.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int unsigned N = RING_N
) (
  input  logic [N-1:0]         ring,
  output logic                 legal,
  output logic [$clog2(N)-1:0] index
);

  localparam int unsigned PW = $clog2(N);

  always_comb begin
    legal = is_onehot(VEC_W'(ring));
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ring[i]) index = PW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/ring_monitor.sv
// Ring counter decoder and integrity checker: tracks lock, flags lock loss
// and counts completed laps while locked.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned LAP_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic [N-1:0]         ring,
  output logic [$clog2(N)-1:0] phase,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 err,
  output logic [LAP_W-1:0]     laps,
  output logic                 lap_tick
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  state_e           r_state, w_state_nxt;
  logic [GW-1:0]    r_good, w_good_nxt;
  logic [N-1:0]     r_prev, w_prev_nxt;
  logic [PW-1:0]    r_phase, w_phase_nxt;
  logic             r_phase_valid, w_phase_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [LAP_W-1:0] r_laps, w_laps_nxt;
  logic             r_lap_tick, w_lap_tick_nxt;

  logic             w_legal;
  logic [PW-1:0]    w_index;
  logic [N-1:0]     w_expected;
  logic             w_match;
  logic [GW-1:0]    w_good_inc;

  ring_onehot_enc #(.N(N)) u_enc (
    .ring  (ring),
    .legal (w_legal),
    .index (w_index)
  );

  assign w_expected = N'(rot_next(VEC_W'(r_prev), N));
  assign w_match    = w_legal && (ring == w_expected);
  assign w_good_inc = r_good + GW'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state       <= ST_HUNT;
      r_good        <= '0;
      r_prev        <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_err         <= 1'b0;
      r_laps        <= '0;
      r_lap_tick    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good        <= w_good_nxt;
      r_prev        <= w_prev_nxt;
      r_phase       <= w_phase_nxt;
      r_phase_valid <= w_phase_valid_nxt;
      r_err         <= w_err_nxt;
      r_laps        <= w_laps_nxt;
      r_lap_tick    <= w_lap_tick_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_good_nxt        = r_good;
    w_prev_nxt        = r_prev;
    w_phase_nxt       = r_phase;
    w_phase_valid_nxt = r_phase_valid;
    w_err_nxt         = 1'b0;
    w_laps_nxt        = r_laps;
    w_lap_tick_nxt    = 1'b0;
    if (en) begin
      w_phase_valid_nxt = w_legal;
      if (w_legal) begin
        w_phase_nxt = w_index;
        w_prev_nxt  = ring;
      end
      case (r_state)
        ST_HUNT: begin
          if (w_legal) begin
            w_state_nxt = ST_CHECK;
            w_good_nxt  = '0;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == GW'(LOCK_CNT)) w_state_nxt = ST_LOCKED;
          end else if (w_legal) begin
            w_good_nxt = '0;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            // Previous sample at the last stage means this advance wraps to phase 0.
            if (r_prev[0]) begin
              w_laps_nxt     = r_laps + LAP_W'(1);
              w_lap_tick_nxt = 1'b1;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = w_legal ? ST_CHECK : ST_HUNT;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign locked      = (r_state == ST_LOCKED);
  assign err         = r_err;
  assign laps        = r_laps;
  assign lap_tick    = r_lap_tick;

endmodule
